// File: rtl/retire_unit.sv
// retire_unit
//   In-order retirement stage fed by the re-order buffer commit port. Each
//   accepted commit beat updates the architectural register file and the
//   retirement map when it writes a non-zero rd. It also returns the
//   physical register that rd previously mapped to through a small freed-register FIFO.
//   The stage counts retired instructions and stops accepting beats after ebreak retires.
//
// Ports
//   clk_i, reset_ni         clock (rising edge), async active-low reset
//   commit_valid_i          commit beat valid (no backpressure)
//   commit_inst_i           committed RV32 instruction
//   commit_pc_i             its PC
//   commit_prd_addr_i       physical destination register
//   commit_prd_value_i      result value
//   free_valid_o/free_prd_o freed physical register (FIFO head)
//   free_ready_i            free list accepts free_prd_o this cycle
//   arf_raddr_i/arf_rdata_o combinational architectural register read
//   retire_valid_o          one-cycle pulse per retired instruction
//   retired_pc_o            PC of the last retired instruction
//   instret_o               retired instruction count (wraps at 2^64)
//   halted_o                sticky, set once ebreak retires
//   free_overflow_o         sticky, set when a freed register is dropped

module retire_unit #(
   parameter int FREE_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        commit_valid_i,
   input  logic [31:0] commit_inst_i,
   input  logic [31:0] commit_pc_i,
   input  logic [4:0]  commit_prd_addr_i,
   input  logic [31:0] commit_prd_value_i,
   output logic        free_valid_o,
   output logic [4:0]  free_prd_o,
   input  logic        free_ready_i,
   input  logic [4:0]  arf_raddr_i,
   output logic [31:0] arf_rdata_o,
   output logic        retire_valid_o,
   output logic [31:0] retired_pc_o,
   output logic [63:0] instret_o,
   output logic        halted_o,
   output logic        free_overflow_o
);

   localparam int PTR_W = $clog2(FREE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FREE_DEPTH);
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic [31:0]      arf [32];
   logic [4:0]       rmap [32];
   logic [4:0]       fifo_mem [FREE_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   logic       accept;
   logic       writes_rd;
   logic [4:0] rd;
   logic       we;
   logic [4:0] old_prd;
   logic       push;
   logic       push_ok;
   logic       pop;
   logic       full;

   assign rd     = commit_inst_i[11:7];
   assign accept = commit_valid_i && !halted_o;

   always_comb begin
      writes_rd = 1'b0;
      case (commit_inst_i[6:0])
         7'b0110111,
         7'b0010111,
         7'b1101111,
         7'b1100111,
         7'b0000011,
         7'b0010011,
         7'b0110011: writes_rd = 1'b1;
         default:    writes_rd = 1'b0;
      endcase
   end

   assign we      = accept && writes_rd && (rd != 5'd0);
   assign old_prd = rmap[rd];
   // Remapping rd to the physical register it already holds frees nothing.
   assign push    = we && (old_prd != commit_prd_addr_i);

   assign free_valid_o = (count != '0);
   assign pop          = free_valid_o && free_ready_i;
   assign full         = (count == CNT_FULL);
   // A pop in the same cycle makes room even when full.
   assign push_ok      = push && (!full || pop);
   assign free_prd_o   = free_valid_o ? fifo_mem[head] : 5'd0;

   assign arf_rdata_o = (arf_raddr_i == 5'd0) ? 32'd0 : arf[arf_raddr_i];

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < 32; i++) begin
            arf[i]  <= 32'd0;
            rmap[i] <= 5'(i);
         end
      end else if (we) begin
         arf[rd]  <= commit_prd_value_i;
         rmap[rd] <= commit_prd_addr_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < FREE_DEPTH; i++) begin
            fifo_mem[i] <= 5'd0;
         end
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         free_overflow_o <= 1'b0;
      end else begin
         if (push_ok) begin
            fifo_mem[tail] <= old_prd;
            tail           <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         if (push_ok && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push_ok) begin
            count <= count - 1'b1;
         end
         if (push && !push_ok) begin
            free_overflow_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         retire_valid_o <= 1'b0;
         retired_pc_o   <= 32'd0;
         instret_o      <= 64'd0;
         halted_o       <= 1'b0;
      end else begin
         retire_valid_o <= accept;
         if (accept) begin
            retired_pc_o <= commit_pc_i;
            instret_o    <= instret_o + 64'd1;
            if (commit_inst_i == EBREAK) begin
               halted_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_retire_unit.sv
// tb_retire_unit
//   Directed testbench for retire_unit. Drives commit beats with hand-computed
//   expected architectural state, free-list output and counters.

module tb_retire_unit;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic        commit_valid_i;
   logic [31:0] commit_inst_i;
   logic [31:0] commit_pc_i;
   logic [4:0]  commit_prd_addr_i;
   logic [31:0] commit_prd_value_i;
   logic        free_valid_o;
   logic [4:0]  free_prd_o;
   logic        free_ready_i;
   logic [4:0]  arf_raddr_i;
   logic [31:0] arf_rdata_o;
   logic        retire_valid_o;
   logic [31:0] retired_pc_o;
   logic [63:0] instret_o;
   logic        halted_o;
   logic        free_overflow_o;

   int n_checks = 0;
   int n_errors = 0;

   retire_unit #(.FREE_DEPTH(4)) dut (
      .clk_i              (clk_i),
      .reset_ni           (reset_ni),
      .commit_valid_i     (commit_valid_i),
      .commit_inst_i      (commit_inst_i),
      .commit_pc_i        (commit_pc_i),
      .commit_prd_addr_i  (commit_prd_addr_i),
      .commit_prd_value_i (commit_prd_value_i),
      .free_valid_o       (free_valid_o),
      .free_prd_o         (free_prd_o),
      .free_ready_i       (free_ready_i),
      .arf_raddr_i        (arf_raddr_i),
      .arf_rdata_o        (arf_rdata_o),
      .retire_valid_o     (retire_valid_o),
      .retired_pc_o       (retired_pc_o),
      .instret_o          (instret_o),
      .halted_o           (halted_o),
      .free_overflow_o    (free_overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Beat is driven 1 ns after a rising edge, sampled at the next edge;
   // returns 1 ns after that edge with valid dropped.
   task automatic beat(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [4:0] prd, input logic [31:0] val);
      commit_valid_i     = 1'b1;
      commit_inst_i      = inst;
      commit_pc_i        = pc;
      commit_prd_addr_i  = prd;
      commit_prd_value_i = val;
      @(posedge clk_i);
      #1;
      commit_valid_i = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_arf(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      arf_raddr_i = addr;
      #1;
      chk(tag, {32'd0, arf_rdata_o}, {32'd0, exp});
   endtask

   initial begin
      reset_ni           = 1'b0;
      commit_valid_i     = 1'b0;
      commit_inst_i      = 32'd0;
      commit_pc_i        = 32'd0;
      commit_prd_addr_i  = 5'd0;
      commit_prd_value_i = 32'd0;
      free_ready_i       = 1'b0;
      arf_raddr_i        = 5'd0;
      repeat (3) @(posedge clk_i);
      #3 reset_ni = 1'b1;
      idle();

      // reset state
      for (int k = 1; k < 32; k++) begin
         arf_raddr_i = 5'(k);
         #1;
         chk("rst_arf", {32'd0, arf_rdata_o}, 64'd0);
      end
      idle();
      chk("rst_free_valid", {63'd0, free_valid_o}, 64'd0);
      chk("rst_free_prd", {59'd0, free_prd_o}, 64'd0);
      chk("rst_instret", instret_o, 64'd0);
      chk("rst_retire_valid", {63'd0, retire_valid_o}, 64'd0);
      chk("rst_retired_pc", {32'd0, retired_pc_o}, 64'd0);
      chk("rst_halted", {63'd0, halted_o}, 64'd0);
      chk("rst_overflow", {63'd0, free_overflow_o}, 64'd0);

      // single write: addi x5,x0,7
      free_ready_i = 1'b1;
      beat(32'h0070_0293, 32'h100, 5'd12, 32'd7);
      chk("sw_retire_valid", {63'd0, retire_valid_o}, 64'd1);
      chk("sw_retired_pc", {32'd0, retired_pc_o}, 64'h100);
      chk("sw_instret", instret_o, 64'd1);
      chk("sw_free_valid", {63'd0, free_valid_o}, 64'd1);
      chk("sw_free_prd", {59'd0, free_prd_o}, 64'd5);
      chk_arf("sw_arf5", 5'd5, 32'd7);
      idle();
      chk("sw_pulse_end", {63'd0, retire_valid_o}, 64'd0);
      chk("sw_popped", {63'd0, free_valid_o}, 64'd0);

      // store, then addi x0: counted, no architectural change
      beat(32'h0051_2023, 32'h104, 5'd30, 32'hdead_beef);
      chk("st_free_valid", {63'd0, free_valid_o}, 64'd0);
      chk("st_instret", instret_o, 64'd2);
      beat(32'h0010_0013, 32'h108, 5'd31, 32'd1);
      chk("x0_free_valid", {63'd0, free_valid_o}, 64'd0);
      chk("x0_instret", instret_o, 64'd3);
      chk("x0_retired_pc", {32'd0, retired_pc_o}, 64'h108);
      chk_arf("x0_arf0", 5'd0, 32'd0);
      chk_arf("x0_arf5", 5'd5, 32'd7);

      // same-rd chain: x3 <- prd20, then x3 <- prd21
      beat(32'h0110_0193, 32'h10c, 5'd20, 32'h11);
      chk("ch_free_prd0", {59'd0, free_prd_o}, 64'd3);
      beat(32'h0220_0193, 32'h110, 5'd21, 32'h22);
      chk("ch_free_valid1", {63'd0, free_valid_o}, 64'd1);
      chk("ch_free_prd1", {59'd0, free_prd_o}, 64'd20);
      chk_arf("ch_arf3", 5'd3, 32'h22);
      idle();
      chk("ch_drained", {63'd0, free_valid_o}, 64'd0);
      chk("ch_instret", instret_o, 64'd5);

      // backpressure: x1..x5 with prd 24..28; old maps are 1,2,21,4,12
      free_ready_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         beat((32'(32'h40 + k) << 20) | (32'(k) << 7) | 32'h13,
              32'h120 + 32'(4 * k), 5'(23 + k), 32'(32'h40 + k));
      end
      chk("bp_overflow", {63'd0, free_overflow_o}, 64'd1);
      chk("bp_instret", instret_o, 64'd10);
      chk("bp_head", {59'd0, free_prd_o}, 64'd1);
      chk_arf("bp_arf2", 5'd2, 32'h42);
      chk_arf("bp_arf5", 5'd5, 32'h45);
      idle();
      chk("bp_hold", {59'd0, free_prd_o}, 64'd1);
      free_ready_i = 1'b1;
      idle();
      chk("bp_pop2", {59'd0, free_prd_o}, 64'd2);
      idle();
      chk("bp_pop21", {59'd0, free_prd_o}, 64'd21);
      idle();
      chk("bp_pop4", {59'd0, free_prd_o}, 64'd4);
      idle();
      chk("bp_empty", {63'd0, free_valid_o}, 64'd0);
      chk("bp_overflow_sticky", {63'd0, free_overflow_o}, 64'd1);

      // halt: ebreak, then addi x6,x0,9 which must be ignored
      beat(32'h0010_0073, 32'h200, 5'd0, 32'd0);
      chk("ht_halted", {63'd0, halted_o}, 64'd1);
      chk("ht_instret", instret_o, 64'd11);
      chk("ht_retire_valid", {63'd0, retire_valid_o}, 64'd1);
      beat(32'h0090_0313, 32'h204, 5'd15, 32'd9);
      chk("ht_instret_hold", instret_o, 64'd11);
      chk("ht_retired_pc", {32'd0, retired_pc_o}, 64'h200);
      chk("ht_no_pulse", {63'd0, retire_valid_o}, 64'd0);
      chk("ht_free_valid", {63'd0, free_valid_o}, 64'd0);
      chk_arf("ht_arf6", 5'd6, 32'd0);

      // asynchronous reset mid-stream
      #1 reset_ni = 1'b0;
      #1;
      chk("ar_halted", {63'd0, halted_o}, 64'd0);
      chk("ar_instret", instret_o, 64'd0);
      chk("ar_overflow", {63'd0, free_overflow_o}, 64'd0);
      chk_arf("ar_arf3", 5'd3, 32'd0);
      reset_ni = 1'b1;
      idle();

      // full FIFO with simultaneous push and pop: nothing dropped
      free_ready_i = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         beat((32'(k) << 7) | 32'h13, 32'h300 + 32'(4 * k), 5'(7 + k), 32'(k));
      end
      free_ready_i = 1'b1;
      beat((32'd5 << 7) | 32'h13, 32'h314, 5'd12, 32'd5);
      chk("fp_overflow", {63'd0, free_overflow_o}, 64'd0);
      chk("fp_head2", {59'd0, free_prd_o}, 64'd2);
      idle();
      chk("fp_head3", {59'd0, free_prd_o}, 64'd3);
      idle();
      chk("fp_head4", {59'd0, free_prd_o}, 64'd4);
      idle();
      chk("fp_head5", {59'd0, free_prd_o}, 64'd5);
      idle();
      chk("fp_empty", {63'd0, free_valid_o}, 64'd0);
      chk("fp_instret", instret_o, 64'd5);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
